board_ram_scheduler: RTL and testbench

- Time-slot scheduler that shares one single-port board-state RAM among three requesters:
  - video read port: dynamic_screen us/them cell lookup;
  - game-logic read/write port, req/ack handshake;
  - built-in clear sequencer that wipes the board.
- Sits between dynamic_screen and the board RAM. One instance per board (us, them).
- Runs on the 100 MHz system clock. Video gets a guaranteed 1-of-4 slot, matching the 25 MHz pixel rate.

---
 rtl/board_pkg.sv | 34 +++
 rtl/board_clear_seq.sv | 57 +++++
 rtl/board_ram_scheduler.sv | 119 +++++++++++
 tb/tb_board_ram_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared constants and types for the board RAM scheduler: cell encodings,
// slot numbering and the FSM state types.
package board_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 2;
   localparam int CELLS  = 100;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      SHIP  = 2'b01,
      HIT   = 2'b10,
      MISS  = 2'b11
   } cell_t;

   localparam logic [1:0] CLEAR_VAL = EMPTY;

   typedef logic [1:0] ph_t;
   localparam ph_t VID_PH = 2'd0;

   typedef enum logic [1:0] {
      G_IDLE,
      G_WAIT,
      G_DATA,
      G_ACK
   } game_state_t;

   typedef enum logic [1:0] {
      C_IDLE,
      C_SWEEP,
      C_DONE
   } clear_state_t;

endpackage

// File: rtl/board_clear_seq.sv
// Board clear sequencer: walks addresses 0..CELLS-1, advancing one cell per
// granted slot, then pulses done for a single cycle.
module board_clear_seq #(
   parameter int ADDR_W = board_pkg::ADDR_W,
   parameter int CELLS  = board_pkg::CELLS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              grant,
   output logic              starting,
   output logic              req,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] addr
);
   import board_pkg::*;

   clear_state_t      state, state_next;
   logic [ADDR_W-1:0] cnt;
   logic              last;

   assign last     = (cnt == ADDR_W'(CELLS - 1));
   assign starting = (state == C_IDLE) && start;
   assign busy     = (state == C_SWEEP);
   assign req      = busy;
   assign done     = (state == C_DONE);
   assign addr     = cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= C_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (starting)
            cnt <= '0;
         else if (busy && grant)
            cnt <= cnt + ADDR_W'(1);
      end
   end

   // NOTE: next-state is defaulted first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         C_IDLE:  if (start) state_next = C_SWEEP;
         C_SWEEP: if (grant && last) state_next = C_DONE;
         C_DONE:  state_next = C_IDLE;
         default: state_next = C_IDLE;
      endcase
   end

endmodule

// File: rtl/board_ram_scheduler.sv
// Shares one single-port board RAM between the video reader (fixed 1-of-4
// slot), the game-logic req/ack port and the clear sequencer.
module board_ram_scheduler #(
   parameter int                ADDR_W    = board_pkg::ADDR_W,
   parameter int                DATA_W    = board_pkg::DATA_W,
   parameter int                CELLS     = board_pkg::CELLS,
   parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(board_pkg::CLEAR_VAL)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_data,
   input  logic              gm_req,
   input  logic              gm_we,
   input  logic [ADDR_W-1:0] gm_addr,
   input  logic [DATA_W-1:0] gm_wdata,
   output logic              gm_ack,
   output logic [DATA_W-1:0] gm_rdata,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   import board_pkg::*;

   localparam logic [ADDR_W:0] CELLS_LIM = CELLS[ADDR_W:0];

   ph_t               ph, ph_next;
   logic              video_edge, capture_edge;
   game_state_t       g_state, g_next;
   logic              gm_issue, gm_bad, gm_in_range;
   logic              clr_req, clr_starting, clr_grant, clear_active;
   logic [ADDR_W-1:0] clr_addr;

   board_clear_seq #(.ADDR_W(ADDR_W), .CELLS(CELLS)) u_clear (
      .clk      (clk),
      .rst      (rst),
      .start    (clear_start),
      .grant    (clr_grant),
      .starting (clr_starting),
      .req      (clr_req),
      .busy     (clear_busy),
      .done     (clear_done),
      .addr     (clr_addr)
   );

   // Decisions are made for the slot being entered, so decode from ph_next.
   assign ph_next      = ph + 2'd1;
   assign video_edge   = (ph_next == VID_PH);
   assign capture_edge = (ph_next == ph_t'(VID_PH + 2'd2));
   assign gm_in_range  = ({1'b0, gm_addr} < CELLS_LIM);
   assign clear_active = clear_busy || clr_starting;
   assign gm_ack       = (g_state == G_ACK);

   // Clear issues wait for an in-flight game op; a starting clear beats a
   // simultaneous game request.
   always_comb begin
      g_next    = g_state;
      clr_grant = 1'b0;
      gm_issue  = 1'b0;
      if (!video_edge && g_state == G_IDLE) begin
         if (clr_req)
            clr_grant = 1'b1;
         else if (gm_req && !clear_active)
            gm_issue = 1'b1;
      end
      case (g_state)
         G_IDLE:  if (gm_issue) g_next = G_WAIT;
         G_WAIT:  g_next = G_DATA;
         G_DATA:  g_next = G_ACK;
         G_ACK:   g_next = G_IDLE;
         default: g_next = G_IDLE;
      endcase
   end

   // NOTE: the RAM array lives outside this block; only the control and
   // output registers here need reset values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ph        <= VID_PH;
         g_state   <= G_IDLE;
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_wdata <= '0;
         vid_data  <= '0;
         gm_rdata  <= '0;
         gm_bad    <= 1'b0;
      end else begin
         ph      <= ph_next;
         g_state <= g_next;

         if (video_edge) begin
            ram_addr <= vid_addr;
            ram_we   <= 1'b0;
         end else if (clr_grant) begin
            ram_addr  <= clr_addr;
            ram_we    <= 1'b1;
            ram_wdata <= CLEAR_VAL;
         end else if (gm_issue) begin
            ram_addr  <= gm_addr;
            ram_we    <= gm_we && gm_in_range;
            ram_wdata <= gm_wdata;
            gm_bad    <= !gm_in_range;
         end else begin
            ram_we <= 1'b0;
         end

         if (capture_edge)
            vid_data <= ram_rdata;

         if (g_state == G_DATA)
            gm_rdata <= gm_bad ? '0 : ram_rdata;
      end
   end

endmodule

// File: tb/tb_board_ram_scheduler.sv
// Directed bench for board_ram_scheduler: behavioural sync-read RAM, a table
// of game ops, and hand sequences for video timing, clear and reset.
module tb_board_ram_scheduler;
   import board_pkg::*;

   localparam int AW = ADDR_W;
   localparam int DW = DATA_W;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] vid_addr;
   logic [DW-1:0] vid_data;
   logic          gm_req, gm_we;
   logic [AW-1:0] gm_addr;
   logic [DW-1:0] gm_wdata;
   logic          gm_ack;
   logic [DW-1:0] gm_rdata;
   logic          clear_start, clear_busy, clear_done;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata = '0;

   always #5 clk = ~clk;

   board_ram_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .vid_addr   (vid_addr),
      .vid_data   (vid_data),
      .gm_req     (gm_req),
      .gm_we      (gm_we),
      .gm_addr    (gm_addr),
      .gm_wdata   (gm_wdata),
      .gm_ack     (gm_ack),
      .gm_rdata   (gm_rdata),
      .clear_start(clear_start),
      .clear_busy (clear_busy),
      .clear_done (clear_done),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   // Board RAM model with bench-side fill/poke access
   logic [DW-1:0] mem [128];
   logic          fill_en = 1'b0, poke_en = 1'b0;
   logic [DW-1:0] fill_val = '0, poke_val = '0;
   logic [AW-1:0] poke_addr = '0;

   always @(posedge clk) begin
      if (fill_en) begin
         for (int i = 0; i < 128; i++) mem[i] <= fill_val;
      end else if (poke_en) begin
         mem[poke_addr] <= poke_val;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   // Phase tracker, video-slot write watch and write histogram
   logic [1:0] tb_ph = 2'd0;
   int         vid_we_viol = 0;
   int         wr_hist [128];
   logic       hist_clr = 1'b0;

   always @(posedge clk) begin
      if (!rst) tb_ph <= 2'd0;
      else      tb_ph <= tb_ph + 2'd1;
      if (rst && tb_ph == 2'd0 && ram_we) vid_we_viol <= vid_we_viol + 1;
      if (hist_clr) begin
         for (int i = 0; i < 128; i++) wr_hist[i] <= 0;
      end else if (rst && ram_we) begin
         wr_hist[ram_addr] <= wr_hist[ram_addr] + 1;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_ph(input logic [1:0] p);
      step();
      for (int i = 0; i < 8 && tb_ph != p; i++) step();
   endtask

   task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
      poke_addr = a; poke_val = v; poke_en = 1'b1;
      step();
      poke_en = 1'b0;
   endtask

   task automatic fill(input logic [DW-1:0] v);
      fill_val = v; fill_en = 1'b1;
      step();
      fill_en = 1'b0;
   endtask

   task automatic gm_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] exp, input string name);
      int  lat;
      logic got;
      gm_we = we; gm_addr = a; gm_wdata = wd; gm_req = 1'b1;
      lat = 0; got = 1'b0;
      while (!got && lat < 8) begin
         step();
         lat++;
         if (gm_ack) got = 1'b1;
      end
      check({name, " ack_seen"}, got, 1);
      check({name, " ack_within_4"}, (lat <= 4), 1);
      if (!we) check({name, " rdata"}, gm_rdata, exp);
      gm_req = 1'b0;
      step();
      check({name, " ack_single"}, gm_ack, 0);
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
   } gm_vec_t;

   gm_vec_t vecs [10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected test end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   cyc, ndone, errs;
      logic got, found, done_first;

      vecs[0] = '{1'b1, 7'd12,  2'b10, 2'b00};
      vecs[1] = '{1'b0, 7'd12,  2'b00, 2'b10};
      vecs[2] = '{1'b1, 7'd50,  2'b11, 2'b00};
      vecs[3] = '{1'b0, 7'd50,  2'b00, 2'b11};
      vecs[4] = '{1'b0, 7'd5,   2'b00, 2'b01};
      vecs[5] = '{1'b0, 7'd120, 2'b00, 2'b00};
      vecs[6] = '{1'b1, 7'd120, 2'b01, 2'b00};
      vecs[7] = '{1'b0, 7'd99,  2'b00, 2'b10};
      vecs[8] = '{1'b1, 7'd99,  2'b01, 2'b00};
      vecs[9] = '{1'b0, 7'd99,  2'b00, 2'b01};

      rst = 1'b0; vid_addr = 7'd5; gm_req = 1'b0; gm_we = 1'b0;
      gm_addr = '0; gm_wdata = '0; clear_start = 1'b0;
      step();
      fill(2'b00);
      poke(7'd5, 2'b01);
      poke(7'd6, 2'b11);
      poke(7'd99, 2'b10);
      poke(7'd120, 2'b11);
      hist_clr = 1'b1; step(); hist_clr = 1'b0;

      check("rst ram_addr", ram_addr, 0);
      check("rst ram_we", ram_we, 0);
      check("rst vid_data", vid_data, 0);
      check("rst gm_ack", gm_ack, 0);
      check("rst clear_busy", clear_busy, 0);
      check("rst clear_done", clear_done, 0);
      rst = 1'b1;

      // Video: first ph=2 captures address 0; next group shows RAM[5]
      wait_ph(2'd2);
      check("vid first capture", vid_data, 0);
      wait_ph(2'd2);
      check("vid addr5 ph2", vid_data, 2'b01);
      vid_addr = 7'd6;
      step(); check("vid stable ph3", vid_data, 2'b01);
      step(); check("vid stable ph0", vid_data, 2'b01);
      step(); check("vid stable ph1", vid_data, 2'b01);
      step(); check("vid addr6 ph2", vid_data, 2'b11);

      for (int i = 0; i < 10; i++)
         gm_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
      check("bad addr not written", mem[120], 2'b11);

      vid_addr = 7'd12;
      wait_ph(2'd3);
      wait_ph(2'd2);
      check("vid reads game write", vid_data, 2'b10);

      // Game request raised during ph=3 must wait out the video slot
      vid_addr = 7'd7;
      wait_ph(2'd3);
      gm_we = 1'b0; gm_addr = 7'd12; gm_req = 1'b1;
      step();
      check("ph0 ram_addr video", ram_addr, 7);
      check("ph0 ram_we", ram_we, 0);
      step();
      check("ph1 ram_addr game", ram_addr, 12);
      check("ph1 no ack", gm_ack, 0);
      step();
      check("ph2 no ack", gm_ack, 0);
      step();
      check("ph3 ack", gm_ack, 1);
      check("ph3 rdata", gm_rdata, 2'b10);
      gm_req = 1'b0;
      step();
      check("ph3 ack single", gm_ack, 0);

      // Clear sweep over a board of 11s
      fill(2'b11);
      hist_clr = 1'b1; step(); hist_clr = 1'b0;
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      check("clear busy", clear_busy, 1);
      cyc = 1; got = 1'b0;
      while (!got && cyc < 200) begin
         step(); cyc++;
         if (clear_done) got = 1'b1;
      end
      check("clear done seen", got, 1);
      check("clear within 138", (cyc <= 138), 1);
      check("busy low at done", clear_busy, 0);
      step();
      check("clear done single", clear_done, 0);
      errs = 0;
      for (int i = 0; i < 128; i++) begin
         if (i < CELLS && wr_hist[i] != 1) errs++;
         if (i >= CELLS && wr_hist[i] != 0) errs++;
      end
      check("clear write histogram", errs, 0);
      errs = 0;
      for (int i = 0; i < CELLS; i++) if (mem[i] != 2'b00) errs++;
      check("clear cells empty", errs, 0);
      gm_op(1'b0, 7'd42, 2'b00, 2'b00, "post-clear read42");

      // Simultaneous clear_start and game read: clear wins
      gm_op(1'b1, 7'd99, 2'b10, 2'b00, "pre-race write99");
      clear_start = 1'b1; gm_we = 1'b0; gm_addr = 7'd99; gm_req = 1'b1;
      step();
      clear_start = 1'b0;
      got = 1'b0; done_first = 1'b0; ndone = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         if (clear_done) begin done_first = 1'b1; ndone++; end
         if (gm_ack) got = 1'b1;
         else step();
      end
      check("race ack seen", got, 1);
      check("race done before ack", done_first, 1);
      check("race rdata cleared", gm_rdata, 2'b00);
      gm_req = 1'b0;
      step();

      // Reset in the middle of a sweep
      gm_op(1'b1, 7'd3, 2'b11, 2'b00, "pre-rst write3");
      gm_op(1'b0, 7'd3, 2'b00, 2'b11, "pre-rst read3");
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (ram_we && ram_addr == 7'd40) found = 1'b1;
         else step();
      end
      check("sweep reached 40", found, 1);
      rst = 1'b0;
      step();
      check("mid rst ram_addr", ram_addr, 0);
      check("mid rst ram_we", ram_we, 0);
      check("mid rst ram_wdata", ram_wdata, 0);
      check("mid rst vid_data", vid_data, 0);
      check("mid rst gm_ack", gm_ack, 0);
      check("mid rst gm_rdata", gm_rdata, 0);
      check("mid rst clear_busy", clear_busy, 0);
      check("mid rst clear_done", clear_done, 0);
      step();
      rst = 1'b1;
      ndone = 0; errs = 0;
      for (int i = 0; i < 160; i++) begin
         step();
         if (clear_done) ndone++;
         if (clear_busy) errs++;
      end
      check("no done after rst", ndone, 0);
      check("no busy after rst", errs, 0);

      check("no write in video slot", vid_we_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
